// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between requesters and the round-robin mux arbiter.
// The request field "rel" is the owner's release strobe ("release" is reserved).
interface mux_rr_arbiter_if #(
  parameter int N     = 4,
  parameter int SEL_W = 2
);
  logic [N-1:0]     req;
  logic             rel;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             timeout;

  modport master (output req, rel, input gnt, sel, busy, timeout);
  modport slave  (input req, rel, output gnt, sel, busy, timeout);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared N:1 mux tree: registered one-hot grant,
// binary select, and a hold counter that bounds every grant to MAX_HOLD cycles.

// Per-requester cell: flags a request sitting at or above the search pointer.
module mux_rr_lane #(
  parameter int IDX   = 0,
  parameter int SEL_W = 2
) (
  input  logic             req,
  input  logic [SEL_W-1:0] ptr,
  output logic             hi
);
  localparam logic [SEL_W-1:0] IDX_V = SEL_W'(IDX);
  assign hi = req && (IDX_V >= ptr);
endmodule

module mux_rr_arbiter #(
  parameter int N        = 4,
  parameter int SEL_W    = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_arbiter_if.slave   bus
);
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N - 1);

  logic [0:0]       state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             timeout;

  // sel always names the current owner while in GRANT
  logic             own_req, end_a, end_b, end_c, grant_end;
  logic [SEL_W-1:0] nxt_ptr, srch_ptr;

  assign own_req   = |(bus.req & gnt);
  assign end_a     = ~own_req;
  assign end_b     = bus.rel;
  assign end_c     = (hold_cnt == HOLD_LAST);
  assign grant_end = (state == GRANT) && (end_a || end_b || end_c);
  assign nxt_ptr   = (sel == LAST_IDX) ? '0 : sel + 1'b1;
  // A finishing grant searches from the advanced pointer in the same edge
  assign srch_ptr  = grant_end ? nxt_ptr : ptr;

  logic [N-1:0] req_hi;

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      mux_rr_lane #(.IDX(i), .SEL_W(SEL_W)) u_lane (
        .req (bus.req[i]),
        .ptr (srch_ptr),
        .hi  (req_hi[i])
      );
    end
  endgenerate

  // Requests at/above the pointer win first; otherwise wrap to the lowest index
  logic [N-1:0]     pick, win_oh;
  logic [SEL_W-1:0] win;
  logic             win_vld, found;

  always_comb begin
    pick    = (|req_hi) ? req_hi : bus.req;
    win_vld = |bus.req;
    win_oh  = pick & (~pick + 1'b1);
    win     = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pick[i] && !found) begin
        win   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else if (state == IDLE) begin
      timeout <= 1'b0;
      if (win_vld) begin
        gnt      <= win_oh;
        sel      <= win;
        busy     <= 1'b1;
        hold_cnt <= '0;
        state    <= GRANT;
      end
    end else begin
      // Only a pure hold expiry counts as a forced end
      timeout <= end_c && !end_a && !end_b;
      if (grant_end) begin
        ptr <= nxt_ptr;
        if (win_vld) begin
          gnt      <= win_oh;
          sel      <= win;
          hold_cnt <= '0;
        end else begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign bus.gnt     = gnt;
  assign bus.sel     = sel;
  assign bus.busy    = busy;
  assign bus.timeout = timeout;

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_busy:   assert property (@(posedge clk) disable iff (rst) busy == (|gnt));
  a_sel:    assert property (@(posedge clk) disable iff (rst) !busy || gnt[sel]);
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scenario bench for mux_rr_arbiter: per-cycle expectations queued at drive time.
module tb_mux_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.N(4), .SEL_W(2)) bus ();

  mux_rr_arbiter #(.N(4), .SEL_W(2), .MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       to;
  } obs_t;

  obs_t sb[$];
  obs_t got, exp_v;
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic obs_t own(input int o, input logic t);
    obs_t r;
    r.gnt  = 4'b0001 << o;
    r.sel  = 2'(o);
    r.busy = 1'b1;
    r.to   = t;
    return r;
  endfunction

  function automatic obs_t idle(input int s);
    obs_t r;
    r.gnt  = 4'b0000;
    r.sel  = 2'(s);
    r.busy = 1'b0;
    r.to   = 1'b0;
    return r;
  endfunction

  // Apply inputs for the next edge, queue the expected post-edge outputs
  task automatic drive(input logic [3:0] r, input logic rl, input obs_t e);
    bus.req = r;
    bus.rel = rl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {bus.gnt, bus.sel, bus.busy, bus.timeout};
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    bus.req = '0;
    bus.rel = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    got = {bus.gnt, bus.sel, bus.busy, bus.timeout};
    n_chk++;
    if (got !== idle(0)) $display("FAIL reset_state got %p want %p", got, idle(0));
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(4'b0100, 1'b0, own(2, 1'b0));
      exp_v = sb.pop_front();
      n_chk++;
      if (got !== exp_v) $display("FAIL reset_pregrant cyc %0d got %p want %p", i, got, exp_v);
      else n_pass++;
    end
    #2 rst = 1'b1;
    #1 got = {bus.gnt, bus.sel, bus.busy, bus.timeout};
    n_chk++;
    if (got !== idle(0)) $display("FAIL reset_async got %p want %p", got, idle(0));
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'b0000, 1'b0, idle(0));
      exp_v = sb.pop_front();
      n_chk++;
      if (got !== exp_v) $display("FAIL reset_idle cyc %0d got %p want %p", i, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(4'b0100, 1'b0, own(2, 1'b0));
      else       drive(4'b0000, 1'b0, idle(2));
      exp_v = sb.pop_front();
      n_chk++;
      if (got !== exp_v) $display("FAIL single cyc %0d got %p want %p", i, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive(4'b1111, (i > 0) && (i % 2 == 0), own((i / 2) % 4, 1'b0));
      exp_v = sb.pop_front();
      n_chk++;
      if (got !== exp_v) $display("FAIL round_robin cyc %0d got %p want %p", i, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < 18; i++) begin
      drive(4'b0011, 1'b0, own((i / 8) % 2, (i == 8) || (i == 16)));
      exp_v = sb.pop_front();
      n_chk++;
      if (got !== exp_v) $display("FAIL timeout cyc %0d got %p want %p", i, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_sole_timeout();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      drive(4'b1000, 1'b0, own(3, (i == 8) || (i == 16)));
      exp_v = sb.pop_front();
      n_chk++;
      if (got !== exp_v) $display("FAIL sole_timeout cyc %0d got %p want %p", i, got, exp_v);
      else n_pass++;
    end
  endtask

  // Release by a sole requester regrants at once and restarts the hold count
  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      drive(4'b0010, i == 1, own(1, i == 9));
      exp_v = sb.pop_front();
      n_chk++;
      if (got !== exp_v) $display("FAIL back_to_back cyc %0d got %p want %p", i, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_coincident();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 8)       drive(4'b0100, 1'b0, own(2, 1'b0));
      else if (i == 8) drive(4'b0000, 1'b1, idle(2));
      else             drive(4'b1111, 1'b0, own(3, 1'b0));
      exp_v = sb.pop_front();
      n_chk++;
      if (got !== exp_v) $display("FAIL coincident cyc %0d got %p want %p", i, got, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    bus.req = '0;
    bus.rel = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_sole_timeout();
    test_back_to_back();
    test_coincident();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one N:1 multiplexer tree, built from our 2:1 mux cells, among N requesters. It accepts per-requester requests and issues a registered one-hot grant. It also drives the binary select bus for the mux tree. A hold counter bounds each grant so that no requester can starve the others.

Parameters:
N, 4, number of requesters (2..16)
SEL_W, 2, select bus width; N <= 2**SEL_W required
MAX_HOLD, 8, maximum consecutive cycles one grant may last (>= 1)

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous active-high reset
Req  input  N  request per requester; level, held until served
Release  input  1  current owner ends its grant this cycle
Gnt  output  N  one-hot grant, registered; all-zero when idle
Sel  output  SEL_W  binary index of current owner, drives mux select
Busy  output  1  high while any grant is active
Timeout  output  1  one-cycle pulse when a grant was forcibly ended by MAX_HOLD

Behaviour:
- Reset (async, immediate, also mid-grant):
  - Gnt=0, Sel=0, Busy=0, Timeout=0.
  - Priority pointer=0; hold_cnt=0; state IDLE.
- States: IDLE, GRANT. All outputs are registered; no combinational path from Req to Gnt or Sel.
- Arbitration search:
  - Scan Req starting at the pointer, ascending, with wrap-around at N-1 -> 0.
  - The first set bit wins.
- IDLE:
  - If Req != 0 at a clock edge: Gnt=onehot(winner), Sel=winner, Busy=1, hold_cnt=0, state GRANT.
  - Latency is 1 cycle from Req sampled to Gnt visible.
  - If Req == 0: remain IDLE.
  - Release is ignored in IDLE.
- GRANT, each edge, let o = current owner. The grant ends when any of the following holds:
  - (a) Req[o]==0
  - (b) Release==1
  - (c) hold_cnt==MAX_HOLD-1
- Otherwise, in GRANT: hold_cnt++ and all outputs are held.
- On grant end:
  - Pointer = (o+1) mod N.
  - Re-run the search in the same edge, using the current Req and the new pointer.
  - If there is a winner: grant it back-to-back with no idle cycle, and reset hold_cnt=0.
  - If there is no winner: Gnt=0, Busy=0, state IDLE.
- Timeout rule:
  - Timeout=1 for exactly the cycle after an end caused only by (c).
  - If (a) or (b) coincide with (c), Timeout stays 0.
- Owner priority after its grant ends:
  - A still-requesting owner, after Release or timeout, has the lowest priority in the next search.
  - If it is the sole requester, it is regranted immediately, with hold_cnt=0.
- A grant therefore lasts at most MAX_HOLD cycles. With MAX_HOLD=1, every grant lasts exactly 1 cycle (pure rotation).
- Sel retains its last value in IDLE, so the mux output does not glitch while idle. Gnt is the authoritative valid indicator.
- Req bits at index >= N do not exist. Sel values >= N are never produced.
- Invariants, all cycles:
  - Gnt is zero or one-hot.
  - Busy == |Gnt.
  - When Busy, Gnt[Sel]==1.

Test Plan:
- Reset/idle: assert Rst mid-grant (owner 2) -> Gnt=0, Busy=0, Sel=0 before next edge. Release Rst with Req=0 for 5 cycles -> all outputs stay 0.
- Single request: Req=4'b0100 at edge k -> Gnt=0100, Sel=2, Busy=1 at k+1. Drop Req at edge k+3 -> Gnt=0, Busy=0 at k+4. Sel stays 2.
- Round-robin: Req=4'b1111 held, MAX_HOLD=8, pulse Release every 2nd granted cycle -> Sel sequence 0,1,2,3,0 with no idle gaps, Timeout never set.
- Timeout: Req=4'b0011 held, no Release, MAX_HOLD=8 -> owner 0 for 8 cycles, then owner 1. Timeout=1 in the first cycle of owner 1's grant. Owner 1 also times out after 8 cycles -> Sel returns to 0.
- Sole requester timeout: Req=4'b1000 held for 20 cycles -> Gnt=1000 continuously. Timeout pulses at cycles 9 and 17 after the grant. Busy never drops.
- Coincident end: on the MAX_HOLD-1 cycle, owner deasserts Req and Release=1 together, other Req=0 -> Timeout=0, Gnt=0 next cycle. Pointer advances (verify via the next simultaneous Req=1111 granting owner+1).
